data_memory: RTL and testbench



---
 rtl/data_memory.sv | 102 ++++++++++
 tb/tb_data_memory.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Off-chip line-granular data memory model: one whole-line read or write per
// request, fixed request-to-ack latency, single-cycle ack strobe.
module data_memory #(
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned LATENCY   = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OFS_W = $clog2(LINE_BITS / 8);
  localparam int unsigned CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic                 ack_c;
  logic                 mem_we_c;

  // Line storage; deliberately has no reset so contents survive rst_i.
  logic [LINE_BITS-1:0] memory [DEPTH];

  // Tag and sub-line offset bits play no part in line selection.
  logic unused_addr_c;
  assign unused_addr_c = ^{addr_i[31:OFS_W+IDX_W], addr_i[OFS_W-1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    ack_c    = 1'b0;
    mem_we_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = WAIT;
          cnt_d   = '0;
          idx_d   = addr_i[OFS_W +: IDX_W];
          wdata_d = data_i;
          write_d = write_i;
        end
      end
      WAIT: begin
        // Request inputs are not looked at here; the latched copy completes.
        if (cnt_q == CNT_LAST) begin
          ack_c    = 1'b1;
          mem_we_c = write_q;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  // Commit at the edge closing the ack cycle, unless reset aborts it.
  always_ff @(posedge clk_i) begin
    if (rst_i && mem_we_c) begin
      memory[idx_q] <= wdata_q;
    end
  end

  assign ack_o  = ack_c;
  assign data_o = ack_c ? memory[idx_q] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: table of whole-line transactions plus
// reset-abort and back-to-back request sequences.
module tb_data_memory;

  localparam int LAT = 10;

  localparam logic [255:0] PRE0  = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] PRE16 = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] PRE17 = {8{32'hA5A5_0F0F}};
  localparam logic [255:0] PRE18 = {32{8'h5A}};
  localparam logic [255:0] ECFA  = {16{16'hECFA}};
  localparam logic [255:0] PX    = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] PY    = {4{64'hFEDC_BA98_7654_3210}};
  localparam logic [255:0] PZ    = {32{8'h77}};

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    int           idx;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [10];

  data_memory dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one single-cycle request, then scramble inputs while it is in flight.
  task automatic run_txn(input vec_t v, input string tag);
    int           ack_at = 0;
    int           n_ack  = 0;
    int           stray  = 0;
    logic [255:0] rd     = '0;
    @(negedge clk_i);
    enable_i = 1'b1;
    addr_i   = v.addr;
    data_i   = v.wdata;
    write_i  = v.wr;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk_i);
      if (ack_o) begin
        n_ack++;
        if (ack_at == 0) ack_at = k;
        rd = data_o;
      end else if (data_o !== '0) begin
        stray++;
      end
      enable_i = 1'b0;
      addr_i   = 32'($urandom);
      data_i   = {8{32'($urandom)}};
      write_i  = 1'($urandom_range(0, 1));
    end
    check($sformatf("%s_ack_cycle", tag), 256'(ack_at), 256'(LAT));
    check($sformatf("%s_ack_count", tag), 256'(n_ack), 256'(1));
    check($sformatf("%s_data_idle_zero", tag), 256'(stray), 256'(0));
    if (v.wr) check($sformatf("%s_mem_line", tag), dut.memory[v.idx], v.exp);
    else      check($sformatf("%s_read_data", tag), rd, v.exp);
  endtask

  initial begin
    int n_ack;
    int bad_ack;
    int bad_dat;

    dut.memory[0]   <= PRE0;
    dut.memory[16]  <= PRE16;
    dut.memory[17]  <= PRE17;
    dut.memory[18]  <= PRE18;
    dut.memory[511] <= '0;

    //           wr    addr           wdata  idx  expected (read data / line after write)
    vecs[0] = '{1'b0, 32'h0000_0000, '0,    0,   PRE0};
    vecs[1] = '{1'b1, 32'h0000_0240, ECFA,  18,  ECFA};
    vecs[2] = '{1'b0, 32'h0000_0240, '0,    18,  ECFA};
    vecs[3] = '{1'b0, 32'h0000_0220, '0,    17,  PRE17};
    vecs[4] = '{1'b0, 32'h0000_021F, '0,    16,  PRE16};
    vecs[5] = '{1'b0, 32'h0000_4200, '0,    16,  PRE16};
    vecs[6] = '{1'b1, 32'h0000_4000, PX,    0,   PX};
    vecs[7] = '{1'b0, 32'h0000_001F, '0,    0,   PX};
    vecs[8] = '{1'b1, 32'hFFFF_FFE0, PY,    511, PY};
    vecs[9] = '{1'b0, 32'h0000_3FE0, '0,    511, PY};

    rst_i    = 1'b0;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    repeat (3) @(negedge clk_i);
    check("reset_ack", 256'(ack_o), 256'(0));
    check("reset_data", data_o, '0);
    rst_i = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a write: no ack, no array update.
    @(negedge clk_i);
    enable_i = 1'b1;
    addr_i   = 32'h0000_0220;
    data_i   = PZ;
    write_i  = 1'b1;
    n_ack    = 0;
    for (int k = 1; k <= LAT + 5; k++) begin
      @(negedge clk_i);
      if (ack_o) n_ack++;
      if (k == 6) begin
        check("abort_ack_after_reset", 256'(ack_o), 256'(0));
        check("abort_data_after_reset", data_o, '0);
      end
      enable_i = 1'b0;
      if (k == 5) rst_i = 1'b0;
      if (k == 6) rst_i = 1'b1;
    end
    check("abort_ack_count", 256'(n_ack), 256'(0));
    check("abort_line_kept", dut.memory[17], PRE17);
    run_txn('{1'b0, 32'h0000_0220, '0, 17, PRE17}, "post_reset");

    // enable_i held high: one ack every LAT+1 cycles.
    @(negedge clk_i);
    enable_i = 1'b1;
    addr_i   = 32'h0000_0000;
    write_i  = 1'b0;
    n_ack    = 0;
    bad_ack  = 0;
    bad_dat  = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk_i);
      if (ack_o !== ((k % (LAT + 1)) == LAT)) bad_ack++;
      if (ack_o) begin
        n_ack++;
        if (data_o !== PX) bad_dat++;
      end
    end
    enable_i = 1'b0;
    check("stream_ack_pattern", 256'(bad_ack), 256'(0));
    check("stream_ack_count", 256'(n_ack), 256'(3));
    check("stream_read_data", 256'(bad_dat), 256'(0));

    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
